// File: rtl/dna_ctrl_pkg.sv
// ============================================================================
//  Module      : dna_ctrl_pkg
//  Description : Shared types and constants for the DNA reader sequencer:
//                FSM state encoding, default sizing and the DNA value used
//                by simulation reader models.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dna_ctrl_pkg;

    // Sequencer states; explicit 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_LATCH = 3'd4,
        ST_ACK   = 3'd5
    } state_t;

    localparam int C_DNA_SIZE_DEFAULT      = 96;
    localparam int C_WB_DATA_WIDTH_DEFAULT = 16;
    localparam int C_DNA_WORDS             = C_DNA_SIZE_DEFAULT / C_WB_DATA_WIDTH_DEFAULT;
    localparam int C_WAIT_CYCLES_DEFAULT   = 512;

    // Value returned by simulation models of the DNA reader.
    localparam logic [95:0] C_SIM_DNA = 96'h76543210FEDCBA9876543210;

    // Index width that never collapses to zero bits.
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage : dna_ctrl_pkg

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter. Searches the request
//                vector starting one position after ptr_i (wrapping modulo
//                NUM_REQ) and returns a one-hot grant of the first requester
//                found; all-zero when nobody requests.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
    import dna_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = clog2_min1(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    logic [PTR_W-1:0] idx;
    logic             found;

    // First requester after the pointer wins; the pointer itself is checked last.
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = PTR_W'((int'(ptr_i) + k) % NUM_REQ);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule : rr_arbiter

`default_nettype wire

// File: rtl/dna_read_ctrl.sv
// ============================================================================
//  Module      : dna_read_ctrl
//  Description : Sequencer/arbiter in front of the FPGA DNA reader. Shares
//                the reader between NUM_REQ requesters round-robin, issues a
//                one-cycle read trigger, waits a fixed settle time (the
//                reader has no done flag), caches the value and serves it as
//                WbDataWidth-bit words. Cache hits skip the hardware read.
//                Optional macro DNA_CTRL_AUTO_READ_EN: perform one hardware
//                read right after reset, without grant or done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dna_read_ctrl
    import dna_ctrl_pkg::*;
#(
    parameter int NUM_REQ       = 3,
    parameter int C_DNA_SIZE    = C_DNA_SIZE_DEFAULT,
    parameter int WbDataWidth   = C_WB_DATA_WIDTH_DEFAULT,
    parameter int C_WAIT_CYCLES = C_WAIT_CYCLES_DEFAULT
) (
    input  logic                                               clk_i,
    input  logic                                               rst_i,
    input  logic [NUM_REQ-1:0]                                 req_i,
    input  logic [NUM_REQ-1:0]                                 force_i,
    output logic [NUM_REQ-1:0]                                 gnt_o,
    output logic [NUM_REQ-1:0]                                 done_o,
    output logic                                               dna_read_o,
    input  logic [C_DNA_SIZE-1:0]                              dna_value_i,
    input  logic [clog2_min1(C_DNA_SIZE/WbDataWidth)-1:0]      word_sel_i,
    output logic [WbDataWidth-1:0]                             word_o,
    output logic [C_DNA_SIZE-1:0]                              dna_value_o,
    output logic                                               dna_valid_o,
    output logic                                               busy_o
);

    localparam int C_WORDS = C_DNA_SIZE / WbDataWidth;
    localparam int PTR_W   = clog2_min1(NUM_REQ);
    localparam int CNT_W   = clog2_min1(C_WAIT_CYCLES);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(C_WAIT_CYCLES - 1);

    state_t                  state_q,     state_d;
    logic [NUM_REQ-1:0]      gnt_q,       gnt_d;
    logic [PTR_W-1:0]        ptr_q,       ptr_d;
    logic [CNT_W-1:0]        cnt_q,       cnt_d;
    logic [C_DNA_SIZE-1:0]   dna_value_q, dna_value_d;
    logic                    dna_valid_q, dna_valid_d;
    logic [WbDataWidth-1:0]  word_q,      word_d;

`ifdef DNA_CTRL_AUTO_READ_EN
    // auto_pend: post-reset read still to be started; auto_run: it is in flight.
    logic                    auto_pend_q, auto_pend_d;
    logic                    auto_run_q,  auto_run_d;
`endif

    logic [NUM_REQ-1:0]      arb_gnt;
    logic [PTR_W-1:0]        win_idx;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req_i (req_i),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt)
    );

    // Encode the held one-hot grant into the index stored as the new pointer.
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_q[i]) begin
                win_idx = PTR_W'(i);
            end
        end
    end

    // Next-state logic of the sequencer and its datapath registers.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        dna_value_d = dna_value_q;
        dna_valid_d = dna_valid_q;
`ifdef DNA_CTRL_AUTO_READ_EN
        auto_pend_d = auto_pend_q;
        auto_run_d  = auto_run_q;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef DNA_CTRL_AUTO_READ_EN
                if (auto_pend_q) begin
                    auto_pend_d = 1'b0;
                    auto_run_d  = 1'b1;
                    state_d     = ST_ISSUE;
                end else
`endif
                if (|req_i) begin
                    gnt_d   = arb_gnt;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // Cache hit unless the winner asks for a forced re-read.
                if (dna_valid_q && !(|(force_i & gnt_q))) begin
                    state_d = ST_ACK;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == C_CNT_LAST) begin
                    state_d = ST_LATCH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_LATCH: begin
                dna_value_d = dna_value_i;
                dna_valid_d = 1'b1;
                state_d     = ST_ACK;
`ifdef DNA_CTRL_AUTO_READ_EN
                // The post-reset read has no requester to acknowledge.
                if (auto_run_q) begin
                    auto_run_d = 1'b0;
                    state_d    = ST_IDLE;
                end
`endif
            end
            ST_ACK: begin
                ptr_d   = win_idx;
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Readout word mux; out-of-range selects read as zero.
    always_comb begin
        word_d = '0;
        if (int'(word_sel_i) < C_WORDS) begin
            word_d = dna_value_q[int'(word_sel_i)*WbDataWidth +: WbDataWidth];
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            dna_value_q <= '0;
            dna_valid_q <= 1'b0;
            word_q      <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            dna_value_q <= dna_value_d;
            dna_valid_q <= dna_valid_d;
            word_q      <= word_d;
        end
    end

`ifdef DNA_CTRL_AUTO_READ_EN
    // Arms the one-shot post-reset read.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            auto_pend_q <= 1'b1;
            auto_run_q  <= 1'b0;
        end else begin
            auto_pend_q <= auto_pend_d;
            auto_run_q  <= auto_run_d;
        end
    end
`endif

    // Outputs are decoded from registered state only, so they are glitch-free.
    assign gnt_o       = gnt_q;
    assign done_o      = (state_q == ST_ACK) ? gnt_q : '0;
    assign dna_read_o  = (state_q == ST_ISSUE);
    assign busy_o      = (state_q != ST_IDLE);
    assign word_o      = word_q;
    assign dna_value_o = dna_value_q;
    assign dna_valid_o = dna_valid_q;

endmodule : dna_read_ctrl

`default_nettype wire

// File: tb/tb_dna_read_ctrl.sv
// ============================================================================
//  Module      : tb_dna_read_ctrl
//  Description : Directed self-checking bench for dna_read_ctrl. Cycle 0 is
//                the IDLE cycle in which a request is first presented; done
//                is expected in the ACK cycle (cycle 2 for a hit, cycle
//                C_WAIT+4 for a hardware read).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dna_read_ctrl;

    localparam int C_WAIT = 512;
    localparam logic [95:0] C_DNA_A = 96'h76543210FEDCBA9876543210;
    localparam logic [95:0] C_DNA_B = 96'h000000000000000000000001;
    localparam logic [95:0] C_DNA_C = 96'hA5A5A5A5_0BADF00D_CAFEBABE;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [2:0]  req_i;
    logic [2:0]  force_i;
    logic [2:0]  gnt_o;
    logic [2:0]  done_o;
    logic        dna_read_o;
    logic [95:0] dna_value_i;
    logic [2:0]  word_sel_i;
    logic [15:0] word_o;
    logic [95:0] dna_value_o;
    logic        dna_valid_o;
    logic        busy_o;

    int checks   = 0;
    int failures = 0;
    int read_pulses = 0;

    always #5 clk = ~clk;

    dna_read_ctrl #(
        .NUM_REQ       (3),
        .C_DNA_SIZE    (96),
        .WbDataWidth   (16),
        .C_WAIT_CYCLES (C_WAIT)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .force_i     (force_i),
        .gnt_o       (gnt_o),
        .done_o      (done_o),
        .dna_read_o  (dna_read_o),
        .dna_value_i (dna_value_i),
        .word_sel_i  (word_sel_i),
        .word_o      (word_o),
        .dna_value_o (dna_value_o),
        .dna_valid_o (dna_valid_o),
        .busy_o      (busy_o)
    );

    // Counts reader trigger pulses.
    always @(posedge clk) begin
        if (dna_read_o) read_pulses <= read_pulses + 1;
    end

    // Waits for the next done pulse; cyc=-1 when the budget expires.
    task automatic wait_done(output int cyc, output logic [2:0] d);
        cyc = -1;
        d   = 3'b000;
        for (int k = 1; k <= C_WAIT + 40; k++) begin
            @(negedge clk);
            if (done_o !== 3'b000) begin
                cyc = k;
                d   = done_o;
                return;
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst_i = 1'b1; req_i = '0; force_i = '0; word_sel_i = '0;
        repeat (3) @(negedge clk);
        checks++; if (gnt_o !== 3'b000) begin failures++; $display("FAIL reset_gnt: got %b expected 000", gnt_o); end
        checks++; if (done_o !== 3'b000) begin failures++; $display("FAIL reset_done: got %b expected 000", done_o); end
        checks++; if (dna_read_o !== 1'b0) begin failures++; $display("FAIL reset_read: got %b expected 0", dna_read_o); end
        checks++; if (word_o !== 16'h0) begin failures++; $display("FAIL reset_word: got %h expected 0000", word_o); end
        checks++; if (dna_value_o !== 96'h0) begin failures++; $display("FAIL reset_value: got %h expected 0", dna_value_o); end
        checks++; if (dna_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", dna_valid_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        rst_i = 1'b0;
    endtask

    task automatic test_miss;
        int k; logic [2:0] d; int p0;
        dna_value_i = C_DNA_A;
        @(negedge clk);
        p0 = read_pulses;
        req_i = 3'b001;
        @(negedge clk);
        checks++; if (gnt_o !== 3'b001) begin failures++; $display("FAIL miss_gnt: got %b expected 001", gnt_o); end
        wait_done(k, d);
        req_i = 3'b000;
        checks++; if (k + 1 != C_WAIT + 4) begin failures++; $display("FAIL miss_latency: got %0d expected %0d", k + 1, C_WAIT + 4); end
        checks++; if (d !== 3'b001) begin failures++; $display("FAIL miss_done: got %b expected 001", d); end
        checks++; if (read_pulses - p0 != 1) begin failures++; $display("FAIL miss_reads: got %0d expected 1", read_pulses - p0); end
        checks++; if (dna_valid_o !== 1'b1) begin failures++; $display("FAIL miss_valid: got %b expected 1", dna_valid_o); end
        checks++; if (dna_value_o !== C_DNA_A) begin failures++; $display("FAIL miss_value: got %h expected %h", dna_value_o, C_DNA_A); end
        @(negedge clk);
        word_sel_i = 3'd0;
        @(negedge clk);
        checks++; if (word_o !== 16'h3210) begin failures++; $display("FAIL word0: got %h expected 3210", word_o); end
        word_sel_i = 3'd5;
        @(negedge clk);
        checks++; if (word_o !== 16'h7654) begin failures++; $display("FAIL word5: got %h expected 7654", word_o); end
        word_sel_i = 3'd3;
        @(negedge clk);
        checks++; if (word_o !== 16'hFEDC) begin failures++; $display("FAIL word3: got %h expected FEDC", word_o); end
        word_sel_i = 3'd6;
        @(negedge clk);
        checks++; if (word_o !== 16'h0000) begin failures++; $display("FAIL word_oob: got %h expected 0000", word_o); end
        word_sel_i = 3'd0;
    endtask

    task automatic test_hit;
        int k; logic [2:0] d; int p0;
        p0 = read_pulses;
        req_i = 3'b010;
        wait_done(k, d);
        checks++; if (gnt_o !== 3'b010) begin failures++; $display("FAIL hit_gnt: got %b expected 010", gnt_o); end
        req_i = 3'b000;
        checks++; if (k != 2) begin failures++; $display("FAIL hit_latency: got %0d expected 2", k); end
        checks++; if (d !== 3'b010) begin failures++; $display("FAIL hit_done: got %b expected 010", d); end
        checks++; if (read_pulses != p0) begin failures++; $display("FAIL hit_reads: got %0d expected %0d", read_pulses, p0); end
        @(negedge clk);
        // Serve requester 0 so the pointer returns to 0.
        req_i = 3'b001;
        wait_done(k, d);
        req_i = 3'b000;
        checks++; if (d !== 3'b001) begin failures++; $display("FAIL hit0_done: got %b expected 001", d); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int k; logic [2:0] d; int p0;
        logic [2:0] exp_d [3];
        int exp_k [3];
        exp_d[0] = 3'b010; exp_d[1] = 3'b100; exp_d[2] = 3'b001;
        exp_k[0] = 2;      exp_k[1] = 3;      exp_k[2] = 3;
        p0 = read_pulses;
        req_i = 3'b111;
        for (int t = 0; t < 3; t++) begin
            wait_done(k, d);
            checks++; if (d !== exp_d[t]) begin failures++; $display("FAIL rr_order%0d: got %b expected %b", t, d, exp_d[t]); end
            checks++; if (k != exp_k[t]) begin failures++; $display("FAIL rr_latency%0d: got %0d expected %0d", t, k, exp_k[t]); end
            req_i = req_i & ~exp_d[t];
        end
        checks++; if (read_pulses != p0) begin failures++; $display("FAIL rr_reads: got %0d expected %0d", read_pulses, p0); end
        @(negedge clk);
    endtask

    task automatic test_force;
        int k; logic [2:0] d; int p0;
        dna_value_i = C_DNA_B;
        p0 = read_pulses;
        req_i = 3'b100; force_i = 3'b100;
        wait_done(k, d);
        req_i = 3'b000; force_i = 3'b000;
        checks++; if (k != C_WAIT + 4) begin failures++; $display("FAIL force_latency: got %0d expected %0d", k, C_WAIT + 4); end
        checks++; if (d !== 3'b100) begin failures++; $display("FAIL force_done: got %b expected 100", d); end
        checks++; if (read_pulses - p0 != 1) begin failures++; $display("FAIL force_reads: got %0d expected 1", read_pulses - p0); end
        checks++; if (dna_value_o !== C_DNA_B) begin failures++; $display("FAIL force_value: got %h expected %h", dna_value_o, C_DNA_B); end
        @(negedge clk);
        word_sel_i = 3'd0;
        @(negedge clk);
        checks++; if (word_o !== 16'h0001) begin failures++; $display("FAIL force_word0: got %h expected 0001", word_o); end
    endtask

    task automatic test_reset_mid_wait;
        int k; logic [2:0] d; int p0;
        req_i = 3'b001; force_i = 3'b001;
        // WAIT starts in cycle 3 with count 0, so count 100 is cycle 103.
        repeat (103) @(negedge clk);
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL midwait_busy: got %b expected 1", busy_o); end
        rst_i = 1'b1; req_i = '0; force_i = '0;
        @(negedge clk);
        checks++; if (gnt_o !== 3'b000) begin failures++; $display("FAIL midrst_gnt: got %b expected 000", gnt_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b expected 0", busy_o); end
        checks++; if (dna_valid_o !== 1'b0) begin failures++; $display("FAIL midrst_valid: got %b expected 0", dna_valid_o); end
        checks++; if (dna_value_o !== 96'h0) begin failures++; $display("FAIL midrst_value: got %h expected 0", dna_value_o); end
        checks++; if (word_o !== 16'h0) begin failures++; $display("FAIL midrst_word: got %h expected 0000", word_o); end
        rst_i = 1'b0;
        dna_value_i = C_DNA_C;
        @(negedge clk);
        p0 = read_pulses;
        req_i = 3'b001;
        repeat (C_WAIT) @(negedge clk);
        checks++; if (dna_value_o !== 96'h0) begin failures++; $display("FAIL early_latch: got %h expected 0", dna_value_o); end
        wait_done(k, d);
        req_i = 3'b000;
        checks++; if (k != 4) begin failures++; $display("FAIL fresh_latency: got %0d expected 4", k); end
        checks++; if (read_pulses - p0 != 1) begin failures++; $display("FAIL fresh_reads: got %0d expected 1", read_pulses - p0); end
        checks++; if (dna_value_o !== C_DNA_C) begin failures++; $display("FAIL fresh_value: got %h expected %h", dna_value_o, C_DNA_C); end
        @(negedge clk);
    endtask

    task automatic test_auto_read;
        int k; logic [2:0] d; int p0;
        p0 = read_pulses;
        dna_value_i = C_DNA_A;
        @(negedge clk);
        checks++; if (dna_read_o !== 1'b1) begin failures++; $display("FAIL auto_read: got %b expected 1", dna_read_o); end
        checks++; if (gnt_o !== 3'b000) begin failures++; $display("FAIL auto_gnt: got %b expected 000", gnt_o); end
        req_i = 3'b001;
        // WAIT, LATCH, IDLE, GRANT, then ACK.
        wait_done(k, d);
        req_i = 3'b000;
        checks++; if (k != C_WAIT + 4) begin failures++; $display("FAIL auto_latency: got %0d expected %0d", k, C_WAIT + 4); end
        checks++; if (d !== 3'b001) begin failures++; $display("FAIL auto_done: got %b expected 001", d); end
        checks++; if (read_pulses - p0 != 1) begin failures++; $display("FAIL auto_reads: got %0d expected 1", read_pulses - p0); end
        checks++; if (dna_value_o !== C_DNA_A) begin failures++; $display("FAIL auto_value: got %h expected %h", dna_value_o, C_DNA_A); end
        @(negedge clk);
    endtask

    initial begin
        rst_i = 1'b1; req_i = '0; force_i = '0; word_sel_i = '0; dna_value_i = '0;
        test_reset();
`ifdef DNA_CTRL_AUTO_READ_EN
        test_auto_read();
        test_hit();
`else
        test_miss();
        test_hit();
        test_back_to_back();
        test_force();
        test_reset_mid_wait();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_dna_read_ctrl

`default_nettype wire
